ps2_key_receiver: RTL and testbench
===================================

PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 20000, giving the idle clk cycles (200 us at 100 MHz) after which a partial frame is abandoned.
REQ-002 SHALL have port clk  input  1  system clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ps2_clk  input  1  raw keyboard clock, asynchronous to clk.
REQ-005 SHALL have port ps2_data  input  1  raw keyboard data, asynchronous to clk.
REQ-006 SHALL have port scan_code  output  8  last accepted non-prefix code.
REQ-007 SHALL have port code_valid  output  1  one-cycle pulse when scan_code, key_break and key_ext update.
REQ-008 SHALL have port key_break  output  1  the code was preceded by 0xF0 (release).
REQ-009 SHALL have port key_ext  output  1  the code was preceded by 0xE0.
REQ-010 SHALL have port space_pressed  output  1  one-cycle pulse on a spacebar make while the spacebar is released.
REQ-011 SHALL have port space_held  output  1  level that is high between a spacebar make and its break.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on a start, parity, stop or timeout error.

Function
REQ-013 SHALL pass ps2_clk and ps2_data through a 2-flop synchronizer, plus one history flop on the clock line; a falling edge is synced clk = 0 while the history flop = 1.
REQ-014 SHALL sample the synced data only on a detected falling edge.
REQ-015 SHALL use FSM states IDLE, DATA, PARITY, STOP.
REQ-016 In IDLE, an edge with data = 0 SHALL move to DATA with the bit count at 0; an edge with data = 1 SHALL stay in IDLE and pulse frame_err.
REQ-017 In DATA, the FSM SHALL shift in 8 bits LSB first, then move to PARITY.
REQ-018 In PARITY, the FSM SHALL accept the sample only if data bits plus parity bit have odd parity, then move to STOP.
REQ-019 In STOP, a sample of 1 with good parity SHALL complete the byte and return to IDLE.
REQ-020 In STOP, a sample of 0 or a bad parity SHALL return to IDLE, pulse frame_err and discard the byte.
REQ-021 SHALL count clk cycles since the last falling edge whenever the FSM is not in IDLE.
REQ-022 When that count reaches TIMEOUT_CYCLES, the FSM SHALL return to IDLE and pulse frame_err.
REQ-023 A completed byte 0xE0 SHALL set a pending-extended flag; no code_valid.
REQ-024 A completed byte 0xF0 SHALL set a pending-break flag; no code_valid.
REQ-025 Any other completed byte SHALL load scan_code, copy the pending flags to key_ext and key_break, clear the pending flags, and pulse code_valid.
REQ-026 code_valid SHALL assert in the clk cycle immediately after the cycle in which the stop-bit falling edge is detected.
REQ-027 A non-extended 0x29 make SHALL set space_held; space_pressed SHALL pulse in the same cycle as code_valid only if space_held was 0.
REQ-028 Typematic repeats of 0x29 SHALL produce code_valid but no further space_pressed.
REQ-029 A non-extended 0x29 break SHALL clear space_held in the code_valid cycle.
REQ-030 Extended codes (key_ext = 1) SHALL never affect space_pressed or space_held.
REQ-031 On frame_err, the pending-extended and pending-break flags SHALL be cleared.
REQ-032 Outputs other than pulses SHALL hold their value until the next code_valid.

Reset
REQ-033 While reset = 1, the block SHALL drive: FSM IDLE; scan_code 0x00; code_valid, key_break, key_ext, space_pressed, space_held, frame_err all 0; pending flags, bit count, shift register and timeout counter 0.
REQ-034 The synchronizer flops SHALL reset to 1, the idle-line level, so no false edge is produced on release.
REQ-035 Reset asserted mid-frame SHALL abandon the frame without a frame_err pulse.

Structure
REQ-036 The FSM state encoding and the constants PS2_EXT = 0xE0, PS2_BREAK = 0xF0 and PS2_SPACE = 0x29 SHALL live in the shared package ps2_pkg.
REQ-037 The 2-flop synchronizer plus edge detector SHALL be the single sub-module ps2_sync_edge, instantiated once for the clock line; the data line SHALL use the synchronizer only.

Verification
REQ-038 Good frame 0x1C (parity 0) -> scan_code = 0x1C, code_valid pulses once, key_break = 0, key_ext = 0, frame_err = 0.
REQ-039 Sequence 0x29, 0x29, 0xF0, 0x29 -> space_pressed pulses once; space_held = 1 after the first byte and 0 after the last byte; three code_valid pulses, the last with key_break = 1.
REQ-040 Sequence 0xE0, 0x29 -> code_valid with key_ext = 1; space_pressed = 0 and space_held = 0.
REQ-041 Frame 0x1C with parity bit 1 -> frame_err pulses, no code_valid, scan_code unchanged.
REQ-042 Start bit plus 4 data bits, then ps2_clk held high for TIMEOUT_CYCLES -> frame_err pulses, FSM in IDLE; a following good frame 0x5A is decoded correctly.
REQ-043 Reset asserted after 6 bits of a frame -> all outputs 0, no frame_err; the next good frame 0x29 gives space_pressed.

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_pkg                                                              |
// | Frame FSM encoding and scan-code constants for the PS/2 receiver.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ps2_pkg;

    typedef logic [1:0] ps2_state_t;

    localparam ps2_state_t IDLE   = 2'd0;
    localparam ps2_state_t DATA   = 2'd1;
    localparam ps2_state_t PARITY = 2'd2;
    localparam ps2_state_t STOP   = 2'd3;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_SPACE = 8'h29;

    // PS/2 frames carry odd parity over the eight data bits plus the parity bit.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_sync_edge                                                        |
// | Two-flop synchronizer with a history flop giving a falling-edge pulse.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    // All flops reset to the idle-high line level so release never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_hist <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_fall = r_hist & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/ps2_key_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_key_receiver                                                     |
// | PS/2 keyboard frame receiver with prefix decode and spacebar tracker.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       key_break,
    output logic       key_ext,
    output logic       space_pressed,
    output logic       space_held,
    output logic       frame_err
);

    localparam int                 c_cnt_w   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT_CYCLES);

    logic               w_clk_fall;
    logic               r_data_meta;
    logic               r_data_sync;
    ps2_state_t         r_state;
    ps2_state_t         w_state_nxt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic               r_par_ok;
    logic [c_cnt_w-1:0] r_idle_cnt;
    logic               r_pend_ext;
    logic               r_pend_brk;
    logic               w_start;
    logic               w_shift;
    logic               w_par_load;
    logic               w_done;
    logic               w_err;

    ps2_sync_edge u_clk_sync (
        .clk     (clk),
        .rst     (reset),
        .i_async (ps2_clk),
        .o_fall  (w_clk_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_data_meta <= ps2_data;
            r_data_sync <= r_data_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // A real edge takes priority over a timeout landing in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift     = 1'b0;
        w_par_load  = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        if (w_clk_fall) begin
            case (r_state)
                IDLE: begin
                    if (!r_data_sync) begin
                        w_start     = 1'b1;
                        w_state_nxt = DATA;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                DATA: begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
                end
                PARITY: begin
                    w_par_load  = 1'b1;
                    w_state_nxt = STOP;
                end
                STOP: begin
                    w_state_nxt = IDLE;
                    if (r_data_sync && r_par_ok) w_done = 1'b1;
                    else                         w_err  = 1'b1;
                end
                default: w_state_nxt = IDLE;
            endcase
        end else if (r_state != IDLE && r_idle_cnt == c_timeout) begin
            w_state_nxt = IDLE;
            w_err       = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_par_ok   <= 1'b0;
            r_idle_cnt <= '0;
        end else begin
            if (w_start)    r_bit_cnt <= 3'd0;
            else if (w_shift) r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_shift)    r_shift  <= {r_data_sync, r_shift[7:1]};
            if (w_par_load) r_par_ok <= parity_ok(r_shift, r_data_sync);
            if (r_state == IDLE || w_clk_fall) r_idle_cnt <= '0;
            else                                r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // Prefix bytes only arm flags; any other byte publishes them with the code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_code     <= 8'h00;
            code_valid    <= 1'b0;
            key_break     <= 1'b0;
            key_ext       <= 1'b0;
            space_pressed <= 1'b0;
            space_held    <= 1'b0;
            frame_err     <= 1'b0;
            r_pend_ext    <= 1'b0;
            r_pend_brk    <= 1'b0;
        end else begin
            code_valid    <= 1'b0;
            space_pressed <= 1'b0;
            frame_err     <= w_err;
            if (w_err) begin
                r_pend_ext <= 1'b0;
                r_pend_brk <= 1'b0;
            end else if (w_done) begin
                if (r_shift == PS2_EXT) begin
                    r_pend_ext <= 1'b1;
                end else if (r_shift == PS2_BREAK) begin
                    r_pend_brk <= 1'b1;
                end else begin
                    scan_code  <= r_shift;
                    key_ext    <= r_pend_ext;
                    key_break  <= r_pend_brk;
                    code_valid <= 1'b1;
                    r_pend_ext <= 1'b0;
                    r_pend_brk <= 1'b0;
                    if (r_shift == PS2_SPACE && !r_pend_ext) begin
                        if (r_pend_brk) begin
                            space_held <= 1'b0;
                        end else begin
                            space_held    <= 1'b1;
                            space_pressed <= ~space_held;
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ps2_key_receiver                                                  |
// | Directed frame table plus timing, timeout and reset sequences.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ps2_key_receiver;

    localparam int c_timeout = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       key_break;
    logic       key_ext;
    logic       space_pressed;
    logic       space_held;
    logic       frame_err;

    int n_checks = 0;
    int n_errors = 0;
    int n_cv = 0;
    int n_sp = 0;
    int n_fe = 0;

    ps2_key_receiver #(.TIMEOUT_CYCLES(c_timeout)) dut (
        .clk           (clk),
        .reset         (reset),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .scan_code     (scan_code),
        .code_valid    (code_valid),
        .key_break     (key_break),
        .key_ext       (key_ext),
        .space_pressed (space_pressed),
        .space_held    (space_held),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    // Pulse counters: every high cycle counts, so a stretched pulse shows up.
    always @(negedge clk) begin
        if (code_valid)    n_cv++;
        if (space_pressed) n_sp++;
        if (frame_err)     n_fe++;
    end

    typedef struct {
        logic [7:0] data;
        logic       bad_par;
        logic       bad_stop;
        int         cv;
        int         sp;
        int         fe;
        logic [7:0] scan;
        logic       brk;
        logic       ext;
        logic       held;
    } vec_t;

    localparam int c_nvec = 21;
    vec_t vecs [c_nvec];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(posedge clk); #1 ps2_data = b;
        repeat (5) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (10) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ bad_par);
        ps2_bit(~bad_stop);
        #1 ps2_data = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    initial begin
        int cv0, sp0, fe0;
        logic [7:0] b;

        vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1, 0, 0, 8'h1C, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'h29, 1'b0, 1'b0, 1, 1, 0, 8'h29, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{8'h29, 1'b0, 1'b0, 1, 0, 0, 8'h29, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{8'hF0, 1'b0, 1'b0, 0, 0, 0, 8'h29, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{8'h29, 1'b0, 1'b0, 1, 0, 0, 8'h29, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{8'hE0, 1'b0, 1'b0, 0, 0, 0, 8'h29, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{8'h29, 1'b0, 1'b0, 1, 0, 0, 8'h29, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{8'h1C, 1'b1, 1'b0, 0, 0, 1, 8'h29, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{8'h5A, 1'b0, 1'b1, 0, 0, 1, 8'h29, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{8'hE0, 1'b0, 1'b0, 0, 0, 0, 8'h29, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{8'h1C, 1'b1, 1'b0, 0, 0, 1, 8'h29, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{8'h5A, 1'b0, 1'b0, 1, 0, 0, 8'h5A, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{8'h29, 1'b0, 1'b0, 1, 1, 0, 8'h29, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{8'hE0, 1'b0, 1'b0, 0, 0, 0, 8'h29, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{8'hF0, 1'b0, 1'b0, 0, 0, 0, 8'h29, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{8'h29, 1'b0, 1'b0, 1, 0, 0, 8'h29, 1'b1, 1'b1, 1'b1};
        vecs[16] = '{8'hF0, 1'b0, 1'b0, 0, 0, 0, 8'h29, 1'b1, 1'b1, 1'b1};
        vecs[17] = '{8'h29, 1'b0, 1'b0, 1, 0, 0, 8'h29, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{8'hF0, 1'b0, 1'b0, 0, 0, 0, 8'h29, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{8'h74, 1'b0, 1'b0, 1, 0, 0, 8'h74, 1'b1, 1'b0, 1'b0};
        vecs[20] = '{8'h1C, 1'b0, 1'b0, 1, 0, 0, 8'h1C, 1'b0, 1'b0, 1'b0};

        repeat (4) @(posedge clk);
        #1;
        chk("rst_scan", scan_code, 8'h00);
        chk("rst_cv", code_valid, 0);
        chk("rst_fe", frame_err, 0);
        chk("rst_held", space_held, 0);
        reset = 1'b0;
        repeat (5) @(posedge clk);

        for (int v = 0; v < c_nvec; v++) begin
            cv0 = n_cv; sp0 = n_sp; fe0 = n_fe;
            send_frame(vecs[v].data, vecs[v].bad_par, vecs[v].bad_stop);
            chk($sformatf("v%0d_cv", v), n_cv - cv0, vecs[v].cv);
            chk($sformatf("v%0d_sp", v), n_sp - sp0, vecs[v].sp);
            chk($sformatf("v%0d_fe", v), n_fe - fe0, vecs[v].fe);
            chk($sformatf("v%0d_scan", v), scan_code, vecs[v].scan);
            chk($sformatf("v%0d_brk", v), key_break, vecs[v].brk);
            chk($sformatf("v%0d_ext", v), key_ext, vecs[v].ext);
            chk($sformatf("v%0d_held", v), space_held, vecs[v].held);
        end

        // code_valid latency: the third clk edge after ps2_clk falls on the stop bit.
        b = 8'h3A;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b);
        @(posedge clk); #1 ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("lat_early", code_valid, 0);
        @(posedge clk);
        #1 chk("lat_hit", code_valid, 1);
        chk("lat_scan", scan_code, 8'h3A);
        @(posedge clk);
        #1 chk("lat_late", code_valid, 0);
        repeat (8) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (10) @(posedge clk);

        // Partial frame abandoned after the idle timeout.
        cv0 = n_cv; fe0 = n_fe;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (50) @(posedge clk);
        chk("to_early_fe", n_fe - fe0, 0);
        repeat (c_timeout) @(posedge clk);
        chk("to_fe", n_fe - fe0, 1);
        chk("to_cv", n_cv - cv0, 0);
        cv0 = n_cv; fe0 = n_fe;
        send_frame(8'h5A, 1'b0, 1'b0);
        chk("to_next_cv", n_cv - cv0, 1);
        chk("to_next_fe", n_fe - fe0, 0);
        chk("to_next_scan", scan_code, 8'h5A);

        // Reset mid-frame after 6 bits, with space_held set beforehand.
        send_frame(8'h29, 1'b0, 1'b0);
        chk("pre_rst_held", space_held, 1);
        fe0 = n_fe;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b0);
        @(posedge clk); #1 reset = 1'b1;
        #2;
        chk("mid_rst_scan", scan_code, 8'h00);
        chk("mid_rst_held", space_held, 0);
        chk("mid_rst_brk", key_break, 0);
        chk("mid_rst_ext", key_ext, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (30) @(posedge clk);
        chk("mid_rst_fe", n_fe - fe0, 0);
        cv0 = n_cv; sp0 = n_sp;
        send_frame(8'h29, 1'b0, 1'b0);
        chk("post_rst_cv", n_cv - cv0, 1);
        chk("post_rst_sp", n_sp - sp0, 1);
        chk("post_rst_held", space_held, 1);
        chk("post_rst_fe", n_fe - fe0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
